// File: rtl/mips_lsu_pkg.sv
// Shared types and decode helpers for the MIPS load/store unit.
// Build macro MIPS_LSU_UNALIGNED_EN makes LWL/LWR/SWL/SWR legal at any byte offset.
package mips_lsu_pkg;

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LBU = 4'd1,
    OP_LH  = 4'd2,
    OP_LHU = 4'd3,
    OP_LW  = 4'd4,
    OP_SB  = 4'd5,
    OP_SH  = 4'd6,
    OP_SW  = 4'd7,
    OP_LWL = 4'd8,
    OP_LWR = 4'd9,
    OP_SWL = 4'd10,
    OP_SWR = 4'd11
  } lsu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_t;

  function automatic logic op_is_store(input logic [3:0] op);
    op_is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW) ||
                  (op == OP_SWL) || (op == OP_SWR);
  endfunction

  // Codes 12-15 are never legal; halves need an even offset, words offset 0.
  function automatic logic op_is_legal(input logic [3:0] op, input logic [1:0] k);
    case (op)
      OP_LB, OP_LBU, OP_SB:   op_is_legal = 1'b1;
      OP_LH, OP_LHU, OP_SH:   op_is_legal = ~k[0];
      OP_LW, OP_SW:           op_is_legal = (k == 2'd0);
`ifdef MIPS_LSU_UNALIGNED_EN
      OP_LWL, OP_LWR,
      OP_SWL, OP_SWR:         op_is_legal = 1'b1;
`endif
      default:                op_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_lsu_lane_align.sv
// Combinational byte-lane steering: byte enables and write lanes for stores,
// extraction/extension and LWL/LWR merging for loads. Big-endian within a word.
module lsu_lane_align
  import mips_lsu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  k,
  input  logic [31:0] wdata,
  input  logic [31:0] rt_old,
  input  logic [31:0] rdata,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic [31:0] load_data
);

  // Byte idx of a register value counted from the MSB (idx 0 = bits 31:24).
  function automatic logic [7:0] wbyte(input logic [31:0] w, input logic [1:0] idx);
    wbyte = w[{~idx, 3'b000} +: 8];
  endfunction

  always_comb begin
    byteenable = 4'b0000;
    case (op)
      OP_LB, OP_LBU, OP_SB:   byteenable = 4'b0001 << k;
      OP_LH, OP_LHU, OP_SH:   byteenable = k[1] ? 4'b1100 : 4'b0011;
      OP_LW, OP_SW:           byteenable = 4'b1111;
      OP_LWL, OP_SWL:         byteenable = 4'b1111 << k;
      OP_LWR, OP_SWR:         byteenable = 4'b1111 >> (2'd3 - k);
      default:                byteenable = 4'b0000;
    endcase
  end

  logic [31:0] lwl_word;
  logic [31:0] lwr_word;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic [7:0] wd_lane;
      logic [1:0] swl_idx;
      logic [1:0] swr_idx;
      logic [2:0] pos_sum;
      logic [1:0] lwl_src;
      logic [1:0] lwr_src;

      // Store lanes: lane j carries register byte (j-k) for SWL, (3-k+j) for SWR.
      assign swl_idx = LANE - k;
      assign swr_idx = LANE + 2'd3 - k;

      always_comb begin
        wd_lane = wbyte(wdata, LANE);
        case (op)
          OP_SB:   wd_lane = wdata[7:0];
          OP_SH:   wd_lane = LANE[0] ? wdata[7:0] : wdata[15:8];
          OP_SWL:  wd_lane = wbyte(wdata, swl_idx);
          OP_SWR:  wd_lane = wbyte(wdata, swr_idx);
          default: wd_lane = wbyte(wdata, LANE);
        endcase
      end

      assign writedata[8*gi +: 8] = wd_lane;

      // Load merge: result byte position gi (MSB first) takes memory byte gi+k
      // for LWL while gi+k<=3, and memory byte gi+k-3 for LWR once gi+k>=3.
      assign pos_sum = {1'b0, LANE} + {1'b0, k};
      assign lwl_src = LANE + k;
      assign lwr_src = LANE + k + 2'd1;
      assign lwl_word[8*(3-gi) +: 8] = (pos_sum <= 3'd3) ? rdata[{lwl_src, 3'b000} +: 8]
                                                          : rt_old[8*(3-gi) +: 8];
      assign lwr_word[8*(3-gi) +: 8] = (pos_sum >= 3'd3) ? rdata[{lwr_src, 3'b000} +: 8]
                                                          : rt_old[8*(3-gi) +: 8];
    end
  endgenerate

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = rdata[{k, 3'b000} +: 8];
  assign ld_half = k[1] ? {rdata[23:16], rdata[31:24]} : {rdata[7:0], rdata[15:8]};

  always_comb begin
    load_data = 32'h0;
    case (op)
      OP_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  load_data = {24'h0, ld_byte};
      OP_LH:   load_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  load_data = {16'h0, ld_half};
      OP_LW:   load_data = {rdata[7:0], rdata[15:8], rdata[23:16], rdata[31:24]};
      OP_LWL:  load_data = lwl_word;
      OP_LWR:  load_data = lwr_word;
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mips_lsu.sv
// MIPS load/store unit: one CPU request at a time onto an Avalon-MM master port.
// MIPS_LSU_UNALIGNED_EN (see package) enables LWL/LWR/SWL/SWR.
module mips_lsu
  import mips_lsu_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_rt_old,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              resp_timeout,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  output logic [31:0]       writedata,
  output logic [3:0]        byteenable,
  input  logic [31:0]       readdata
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  lsu_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic [1:0]        k_q, k_d;
  logic [31:0]       rt_q, rt_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [31:0]       writedata_q, writedata_d;
  logic [3:0]        byteenable_q, byteenable_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              resp_timeout_q, resp_timeout_d;

  logic [3:0]  align_op;
  logic [1:0]  align_k;
  logic [3:0]  align_be;
  logic [31:0] align_wd;
  logic [31:0] align_ld;

  // Shared aligner: request fields while idle, latched op/offset during the access.
  assign align_op = (state_q == ST_IDLE) ? req_op : op_q;
  assign align_k  = (state_q == ST_IDLE) ? req_addr[1:0] : k_q;

  lsu_lane_align u_align (
    .op         (align_op),
    .k          (align_k),
    .wdata      (req_wdata),
    .rt_old     (rt_q),
    .rdata      (readdata),
    .byteenable (align_be),
    .writedata  (align_wd),
    .load_data  (align_ld)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    op_d           = op_q;
    k_d            = k_q;
    rt_d           = rt_q;
    read_d         = read_q;
    write_d        = write_q;
    address_d      = address_q;
    writedata_d    = writedata_q;
    byteenable_d   = byteenable_q;
    resp_valid_d   = 1'b0;
    resp_rdata_d   = 32'h0;
    resp_err_d     = 1'b0;
    resp_timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d = req_op;
          k_d  = req_addr[1:0];
          rt_d = req_rt_old;
          if (op_is_legal(req_op, req_addr[1:0])) begin
            state_d      = ST_BUS;
            cnt_d        = '0;
            read_d       = ~op_is_store(req_op);
            write_d      = op_is_store(req_op);
            address_d    = {req_addr[ADDR_W-1:2], 2'b00};
            writedata_d  = align_wd;
            byteenable_d = align_be;
          end else begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end
        end
      end
      ST_BUS: begin
        // A completing transfer wins over a timeout reached in the same cycle.
        if (!waitrequest) begin
          state_d      = ST_RESP;
          read_d       = 1'b0;
          write_d      = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = op_is_store(op_q) ? 32'h0 : align_ld;
        end else if ((TIMEOUT > 0) && (cnt_q == TO_VAL)) begin
          state_d        = ST_RESP;
          read_d         = 1'b0;
          write_d        = 1'b0;
          resp_valid_d   = 1'b1;
          resp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      op_q           <= 4'h0;
      k_q            <= 2'd0;
      rt_q           <= 32'h0;
      read_q         <= 1'b0;
      write_q        <= 1'b0;
      address_q      <= '0;
      writedata_q    <= 32'h0;
      byteenable_q   <= 4'h0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= 32'h0;
      resp_err_q     <= 1'b0;
      resp_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      op_q           <= op_d;
      k_q            <= k_d;
      rt_q           <= rt_d;
      read_q         <= read_d;
      write_q        <= write_d;
      address_q      <= address_d;
      writedata_q    <= writedata_d;
      byteenable_q   <= byteenable_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_err_q     <= resp_err_d;
      resp_timeout_q <= resp_timeout_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE) && !reset;
  assign address      = address_q;
  assign read         = read_q;
  assign write        = write_q;
  assign writedata    = writedata_q;
  assign byteenable   = byteenable_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_err     = resp_err_q;
  assign resp_timeout = resp_timeout_q;

endmodule

// File: tb/tb_mips_lsu.sv
// Directed self-checking bench for mips_lsu (TIMEOUT=4); expectations follow
// the big-endian lane mapping and switch on MIPS_LSU_UNALIGNED_EN.
module tb_mips_lsu;
  import mips_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'h0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] req_rt_old = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        resp_timeout;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest = 1'b0;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata = 32'h0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mips_lsu #(.TIMEOUT(4), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rt_old(req_rt_old),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .resp_timeout(resp_timeout), .address(address), .read(read), .write(write),
    .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata)
  );

  // Presents one request for a single cycle; returns at the falling edge of
  // the first cycle after acceptance.
  task automatic send(input logic [3:0] op, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] rt);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_rt_old = rt;
    $display("txn op=%0d addr=%h wdata=%h rt_old=%h", op, addr, wd, rt);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", req_ready); end
    n_checks++; if ({read, write, resp_valid, resp_err, resp_timeout} !== 5'b0) begin n_fail++; $display("FAIL rst_ctrl: got %b want 00000", {read, write, resp_valid, resp_err, resp_timeout}); end
    n_checks++; if ({address, writedata, byteenable, resp_rdata} !== 100'h0) begin n_fail++; $display("FAIL rst_data: got addr=%h wd=%h be=%b rd=%h want all 0", address, writedata, byteenable, resp_rdata); end
    reset = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_release: got %b want 1", req_ready); end
  endtask

  task automatic test_stores();
    logic [3:0]  op [5];
    logic [31:0] ad [5];
    logic [31:0] wd [5];
    logic [3:0]  be [5];
    logic [31:0] ex [5];
    logic [31:0] mask;
    op = '{OP_SW, OP_SB, OP_SB, OP_SH, OP_SH};
    ad = '{32'h100, 32'h101, 32'h102, 32'h102, 32'h100};
    wd = '{32'h11223344, 32'hDEADBEEF, 32'hDEADBEEF, 32'hCAFE1234, 32'hCAFE1234};
    be = '{4'b1111, 4'b0010, 4'b0100, 4'b1100, 4'b0011};
    ex = '{32'h44332211, 32'h0000EF00, 32'h00EF0000, 32'h34120000, 32'h00003412};
    waitrequest = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mask = {{8{be[i][3]}}, {8{be[i][2]}}, {8{be[i][1]}}, {8{be[i][0]}}};
      send(op[i], ad[i], wd[i], 32'h0);
      n_checks++; if ({write, read} !== 2'b10) begin n_fail++; $display("FAIL st_strobe[%0d]: got w/r=%b want 10", i, {write, read}); end
      n_checks++; if (address !== {ad[i][31:2], 2'b00}) begin n_fail++; $display("FAIL st_addr[%0d]: got %h want %h", i, address, {ad[i][31:2], 2'b00}); end
      n_checks++; if (byteenable !== be[i]) begin n_fail++; $display("FAIL st_be[%0d]: got %b want %b", i, byteenable, be[i]); end
      n_checks++; if ((writedata & mask) !== ex[i]) begin n_fail++; $display("FAIL st_wdata[%0d]: got %h want %h", i, writedata & mask, ex[i]); end
      @(negedge clk);
      n_checks++; if ({resp_valid, resp_err, resp_timeout, write} !== 4'b1000) begin n_fail++; $display("FAIL st_resp[%0d]: got v/e/t/w=%b want 1000", i, {resp_valid, resp_err, resp_timeout, write}); end
    end
  endtask

  task automatic test_loads();
    logic [3:0]  op [7];
    logic [31:0] ad [7];
    logic [31:0] rd [7];
    logic [3:0]  be [7];
    logic [31:0] ex [7];
    op = '{OP_LB, OP_LBU, OP_LW, OP_LH, OP_LHU, OP_LH, OP_LB};
    ad = '{32'h103, 32'h103, 32'h104, 32'h102, 32'h102, 32'h100, 32'h101};
    rd = '{32'h80000000, 32'h80000000, 32'h44332211, 32'h80F01234, 32'h80F01234, 32'h80F01234, 32'h80F01234};
    be = '{4'b1000, 4'b1000, 4'b1111, 4'b1100, 4'b1100, 4'b0011, 4'b0010};
    ex = '{32'hFFFFFF80, 32'h00000080, 32'h11223344, 32'hFFFFF080, 32'h0000F080, 32'h00003412, 32'h00000012};
    waitrequest = 1'b0;
    for (int i = 0; i < 7; i++) begin
      readdata = rd[i];
      send(op[i], ad[i], 32'h0, 32'h0);
      n_checks++; if ({read, write} !== 2'b10) begin n_fail++; $display("FAIL ld_strobe[%0d]: got r/w=%b want 10", i, {read, write}); end
      n_checks++; if (byteenable !== be[i]) begin n_fail++; $display("FAIL ld_be[%0d]: got %b want %b", i, byteenable, be[i]); end
      @(negedge clk);
      n_checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin n_fail++; $display("FAIL ld_resp[%0d]: got v=%b e=%b want v=1 e=0", i, resp_valid, resp_err); end
      n_checks++; if (resp_rdata !== ex[i]) begin n_fail++; $display("FAIL ld_rdata[%0d]: got %h want %h", i, resp_rdata, ex[i]); end
    end
  endtask

  task automatic test_misaligned();
    logic [3:0]  op [7];
    logic [31:0] ad [7];
    op = '{OP_LH, OP_LHU, OP_LW, OP_SH, OP_SW, 4'd12, 4'd15};
    ad = '{32'h101, 32'h103, 32'h102, 32'h103, 32'h101, 32'h100, 32'h100};
    waitrequest = 1'b0;
    readdata = 32'hFFFFFFFF;
    for (int i = 0; i < 7; i++) begin
      send(op[i], ad[i], 32'h55555555, 32'h0);
      n_checks++; if ({read, write} !== 2'b00) begin n_fail++; $display("FAIL mis_bus[%0d]: got r/w=%b want 00", i, {read, write}); end
      n_checks++; if ({resp_valid, resp_err, resp_timeout} !== 3'b110) begin n_fail++; $display("FAIL mis_resp[%0d]: got v/e/t=%b want 110", i, {resp_valid, resp_err, resp_timeout}); end
      n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL mis_rdata[%0d]: got %h want 0", i, resp_rdata); end
      @(negedge clk);
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL mis_single[%0d]: got %b want 0", i, resp_valid); end
    end
  endtask

  task automatic test_wait_states();
    waitrequest = 1'b1;
    send(OP_SW, 32'h208, 32'hA1B2C3D4, 32'h0);
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h500;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL ws_ready: got %b want 0", req_ready); end
    for (int c = 0; c < 3; c++) begin
      n_checks++; if ({write, read, address, writedata, byteenable} !== {2'b10, 32'h208, 32'hD4C3B2A1, 4'hF}) begin n_fail++; $display("FAIL ws_hold[%0d]: got w=%b r=%b a=%h wd=%h be=%b", c, write, read, address, writedata, byteenable); end
      if (c == 2) waitrequest = 1'b0;
      @(negedge clk);
    end
    req_valid = 1'b0;
    n_checks++; if ({resp_valid, resp_timeout, write} !== 3'b100) begin n_fail++; $display("FAIL ws_resp: got v/t/w=%b want 100", {resp_valid, resp_timeout, write}); end
    @(negedge clk);
    n_checks++; if ({read, resp_valid} !== 2'b00) begin n_fail++; $display("FAIL ws_no_queue: got r/v=%b want 00", {read, resp_valid}); end
  endtask

  task automatic test_timeout();
    int cyc;
    cyc = 0;
    waitrequest = 1'b1;
    send(OP_LW, 32'h300, 32'h0, 32'h0);
    for (int i = 0; i < 20 && read === 1'b1; i++) begin
      cyc++;
      @(negedge clk);
    end
    n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL to_read_cycles: got %0d want 5", cyc); end
    n_checks++; if ({resp_valid, resp_timeout, resp_err} !== 3'b110) begin n_fail++; $display("FAIL to_resp: got v/t/e=%b want 110", {resp_valid, resp_timeout, resp_err}); end
    waitrequest = 1'b0;
    @(negedge clk);
    n_checks++; if ({resp_valid, req_ready} !== 2'b01) begin n_fail++; $display("FAIL to_idle: got v/ready=%b want 01", {resp_valid, req_ready}); end
  endtask

  task automatic test_timeout_edge();
    waitrequest = 1'b1;
    send(OP_LW, 32'h304, 32'h0, 32'h0);
    repeat (4) @(negedge clk);
    waitrequest = 1'b0;
    readdata = 32'h01020304;
    n_checks++; if (read !== 1'b1) begin n_fail++; $display("FAIL toe_read: got %b want 1", read); end
    @(negedge clk);
    n_checks++; if ({resp_valid, resp_timeout} !== 2'b10) begin n_fail++; $display("FAIL toe_resp: got v/t=%b want 10", {resp_valid, resp_timeout}); end
    n_checks++; if (resp_rdata !== 32'h04030201) begin n_fail++; $display("FAIL toe_rdata: got %h want 04030201", resp_rdata); end
  endtask

  task automatic test_reset_abort();
    int seen;
    seen = 0;
    waitrequest = 1'b1;
    send(OP_SW, 32'h400, 32'h12345678, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL ra_ready_in_reset: got %b want 0", req_ready); end
    @(negedge clk);
    n_checks++; if ({write, read, resp_valid} !== 3'b000) begin n_fail++; $display("FAIL ra_abort: got w/r/v=%b want 000", {write, read, resp_valid}); end
    n_checks++; if (address !== 32'h0) begin n_fail++; $display("FAIL ra_addr: got %h want 0", address); end
    reset = 1'b0;
    waitrequest = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL ra_ready: got %b want 1", req_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL ra_no_resp: got %0d strobes want 0", seen); end
  endtask

  task automatic test_unaligned();
    logic [3:0]  op [4];
    logic [31:0] ad [4];
    logic [3:0]  be [4];
    logic [31:0] ex [4];
    logic [31:0] mask;
    op = '{OP_LWL, OP_LWR, OP_SWL, OP_SWR};
    ad = '{32'h202, 32'h201, 32'h201, 32'h202};
    be = '{4'b1100, 4'b0011, 4'b1110, 4'b0111};
    ex = '{32'h3344CCDD, 32'hAABB1122, 32'h33221100, 32'h00443322};
    waitrequest = 1'b0;
    readdata = 32'h44332211;
    for (int i = 0; i < 4; i++) begin
      mask = {{8{be[i][3]}}, {8{be[i][2]}}, {8{be[i][1]}}, {8{be[i][0]}}};
      send(op[i], ad[i], 32'h11223344, 32'hAABBCCDD);
`ifdef MIPS_LSU_UNALIGNED_EN
      n_checks++; if (byteenable !== be[i]) begin n_fail++; $display("FAIL ua_be[%0d]: got %b want %b", i, byteenable, be[i]); end
      if (i >= 2) begin
        n_checks++; if ((writedata & mask) !== ex[i]) begin n_fail++; $display("FAIL ua_wdata[%0d]: got %h want %h", i, writedata & mask, ex[i]); end
      end
      @(negedge clk);
      n_checks++; if ({resp_valid, resp_err} !== 2'b10) begin n_fail++; $display("FAIL ua_resp[%0d]: got v/e=%b want 10", i, {resp_valid, resp_err}); end
      if (i < 2) begin
        n_checks++; if (resp_rdata !== ex[i]) begin n_fail++; $display("FAIL ua_rdata[%0d]: got %h want %h", i, resp_rdata, ex[i]); end
      end
`else
      n_checks++; if ({read, write, resp_valid, resp_err} !== 4'b0011) begin n_fail++; $display("FAIL ua_illegal[%0d]: got r/w/v/e=%b want 0011 (mask %h)", i, {read, write, resp_valid, resp_err}, mask); end
      n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL ua_rdata0[%0d]: got %h want 0", i, resp_rdata); end
      @(negedge clk);
`endif
    end
  endtask

  initial begin
    test_reset();
    test_stores();
    test_loads();
    test_misaligned();
    test_wait_states();
    test_timeout();
    test_timeout_edge();
    test_unaligned();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mips_lsu.md
MIPS_LSU -- requirements
Module: mips_lsu

Interface
REQ-001 Parameter TIMEOUT, default 256, SHALL set the maximum consecutive waitrequest-high cycles tolerated per bus access; 0 disables the timeout.
REQ-002 Parameter ADDR_W, default 32, SHALL set the width of req_addr and address.
REQ-003 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1; req_ready  out  1: CPU request handshake, accepted when both are high.
REQ-006 req_op  in  4  lsu_op_t; req_addr  in  ADDR_W  byte address; req_wdata  in  32  store data; req_rt_old  in  32  old rt value for LWL/LWR merge.
REQ-007 resp_valid  out  1  one-cycle result strobe; resp_rdata  out  32  load result; resp_err  out  1  misaligned or illegal op; resp_timeout  out  1  bus timeout.
REQ-008 address  out  ADDR_W; read  out  1; write  out  1; waitrequest  in  1; writedata  out  32; byteenable  out  4; readdata  in  32: Avalon-MM master.

Function
REQ-009 States SHALL be IDLE, BUS and RESP; req_ready SHALL equal (state==IDLE && !reset).
REQ-010 On acceptance of a legal, aligned op, the next state SHALL be BUS, with address = {req_addr[ADDR_W-1:2],2'b00} and all bus outputs registered.
REQ-011 In BUS, read or write, address, writedata and byteenable SHALL stay constant until the cycle waitrequest is low; in that cycle, readdata SHALL be captured and the next state SHALL be RESP.
REQ-012 In RESP, resp_valid SHALL be high for exactly one cycle, with read and write low; the next state SHALL be IDLE. Best-case latency from acceptance to resp_valid is 2 cycles.
REQ-013 Byte offset k = req_addr[1:0] SHALL map to byteenable[k] and lane bits [8k+7:8k]; words and halves are big-endian, so the lowest-address byte is the most significant.
REQ-014 SB: byteenable one-hot at bit k, req_wdata[7:0] replicated on all lanes.
REQ-015 SH: k=0 gives byteenable 0011, lane0=wdata[15:8], lane1=wdata[7:0]; k=2 gives 1100 with the same ordering on lanes 2 and 3.
REQ-016 SW: byteenable 1111, lane0=wdata[31:24], lane1=wdata[23:16], lane2=wdata[15:8], lane3=wdata[7:0].
REQ-017 Loads SHALL drive the same byteenable as the equivalent store. LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend, and LW SHALL return {lane0,lane1,lane2,lane3}.
REQ-018 Misalignment (halfword with k odd; word with k!=0) or an illegal op code SHALL skip the bus and go to RESP with resp_err=1 and resp_rdata=0.
REQ-019 Timeout: a counter SHALL clear on entry to BUS and increment each cycle waitrequest is high. When the counter equals TIMEOUT (TIMEOUT>0), read and write SHALL drop the next cycle and the block SHALL enter RESP with resp_timeout=1.
REQ-020 If waitrequest goes low in the same cycle the timeout is reached, the access SHALL complete normally with resp_timeout=0.
REQ-021 req_valid in any state other than IDLE SHALL be ignored; no request is ever queued.

Reset
REQ-022 On reset, the state SHALL be IDLE and the counter 0, and read, write, resp_valid, resp_err and resp_timeout SHALL be 0. address, writedata, byteenable and resp_rdata SHALL be 0.
REQ-023 Reset during BUS SHALL abort the access: read and write SHALL be 0 from the next cycle, and no resp_valid SHALL be produced.

Configuration
REQ-024 Macro MIPS_LSU_UNALIGNED_EN defined: LWL, LWR, SWL and SWR SHALL be legal at any offset k.
REQ-025 LWL SHALL return memory bytes k..3 in the upper positions, with the low 8k bits taken from req_rt_old. LWR SHALL return memory bytes 0..k in the low positions, with the upper bits taken from req_rt_old.
REQ-026 SWL SHALL enable bytes k..3 with wdata's top 4-k bytes. SWR SHALL enable bytes 0..k with wdata's low k+1 bytes.
REQ-027 Macro undefined: those four ops SHALL be treated as illegal (REQ-018).

Structure
REQ-028 package.v SHALL hold lsu_op_t (LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7, LWL=8, LWR=9, SWL=10, SWR=11; 12-15 illegal) and lsu_state_t.
REQ-029 A combinational sub-module lsu_lane_align SHALL generate byteenable and writedata, and perform load extraction and merging.

Verification
REQ-030 SW addr 0x100, wdata 0x11223344, waitrequest low -> write=1, address 0x100, byteenable 1111, writedata 0x44332211; resp_valid 2 cycles after acceptance.
REQ-031 LB addr 0x103, readdata 0x80000000 -> byteenable 1000, resp_rdata 0xFFFFFF80; LBU with the same stimulus -> 0x00000080.
REQ-032 LH addr 0x101 -> no read asserted, resp_err=1 one cycle after acceptance.
REQ-033 TIMEOUT=4, LW with waitrequest held high -> read high for 5 cycles, then resp_valid with resp_timeout=1.
REQ-034 With the macro defined: LWL addr 0x202, rt_old 0xAABBCCDD, readdata 0x44332211 -> resp_rdata 0x3344CCDD. Without the macro -> resp_err=1.
REQ-035 Reset asserted on the 3rd waitrequest-high cycle of an SW -> write=0 the next cycle, no resp_valid, req_ready=1 after reset is released.
